top_coprocessor: RTL and testbench

- Fuzzy-logic coprocessor: fuzzifies temperature T and its rate dT with trapezoidal membership functions (MFs), evaluates a 3x3 Mamdani min rule base and defuzzifies by weighted singleton average.
- Produces a control percentage G_out in 0..100.
- dT is either external or estimated internally from successive T samples.
- Sits as the top of the coprocessor datapath, driven by a host register interface.

---
 rtl/fuzzy_pkg.sv | 26 ++
 rtl/top_coprocessor_if.sv | 26 ++
 rtl/trap_mf.sv | 43 ++++
 rtl/top_coprocessor.sv | 150 +++++++++++++++
 tb/tb_top_coprocessor.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the fuzzy-logic coprocessor datapath.
package fuzzy_pkg;

  typedef logic [15:0] q15_t;

  localparam q15_t Q15_ONE = 16'h7FFF;
  localparam q15_t EPS     = 16'h0001;

  // Rule singletons in percent, row = T term, column = dT term (neg, zero, pos).
  localparam int unsigned G_SGL [9] = '{100, 50, 30, 50, 50, 50, 80, 50, 0};

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
  } mf_t;

  // Percent singleton scaled to Q15 with round-to-nearest.
  function automatic int unsigned gq_of(input int unsigned g);
    int unsigned r;
    r = (g * 32'd32767 + 32'd50) / 32'd100;
    return (r > 32'd32767) ? 32'd32767 : r;
  endfunction

endpackage

// File: rtl/top_coprocessor_if.sv
// Host-side register bundle of the fuzzy coprocessor.
interface top_coprocessor_if;
  import fuzzy_pkg::*;

  logic              start;
  logic              init;
  logic              reg_mode;
  logic              dt_mode;
  logic signed [7:0] t_in;
  logic signed [7:0] dt_in;
  mf_t [2:0]         t_mf;   // index 0 = neg, 1 = zero, 2 = pos
  mf_t [2:0]         dt_mf;
  logic              valid;
  logic [7:0]        g_out;

  modport master (
    output start, init, reg_mode, dt_mode, t_in, dt_in, t_mf, dt_mf,
    input  valid, g_out
  );

  modport slave (
    input  start, init, reg_mode, dt_mode, t_in, dt_in, t_mf, dt_mf,
    output valid, g_out
  );

endinterface

// File: rtl/trap_mf.sv
// Combinational trapezoidal membership function, Q15 output.
module trap_mf
  import fuzzy_pkg::*;
(
  input  logic signed [7:0] x_i,
  input  mf_t               mf_i,
  output q15_t              mu_o
);

  logic signed [8:0] x, a, b, c, d;
  logic [8:0]        num, den;
  logic [23:0]       quo;

  assign x = {x_i[7], x_i};
  assign a = {mf_i.a[7], mf_i.a};
  assign b = {mf_i.b[7], mf_i.b};
  assign c = {mf_i.c[7], mf_i.c};
  assign d = {mf_i.d[7], mf_i.d};

  always_comb begin
    num  = '0;
    den  = 9'd1;
    quo  = '0;
    mu_o = '0;
    if (x <= a || x >= d) begin
      mu_o = '0;
    end else if (x >= b && x <= c) begin
      mu_o = Q15_ONE;
    end else begin
      if (x < b) begin
        num = 9'(x - a);
        den = 9'(b - a);
      end else begin
        num = 9'(d - x);
        den = 9'(d - c);
      end
      if (den == 9'd0) den = 9'd1;
      quo  = {num, 15'b0} / {15'b0, den};
      mu_o = (quo > 24'h007FFF) ? Q15_ONE : quo[15:0];
    end
  end

endmodule

// File: rtl/top_coprocessor.sv
// Fuzzy coprocessor: 3x3 Mamdani min rules, singleton defuzzification,
// five register stages from start edge to result strobe.
module top_coprocessor
  import fuzzy_pkg::*;
(
  input logic              clk,
  input logic              rst,
  top_coprocessor_if.slave bus_io
);

  logic              start_q, init_q, start_edge, init_edge, force_zero;
  logic              primed_q;
  logic signed [7:0] t_prev_q, est_dt;
  logic signed [8:0] t_diff;

  logic              e_vld_q, e_force_q, e_rm_q;
  logic signed [7:0] e_t_q, e_dt_q;
  mf_t [2:0]         e_tmf_q, e_dtmf_q;

  q15_t [2:0]        mu_t, mu_d;
  q15_t [8:0]        w_d, w_q;
  logic              fr_vld_q, fr_force_q, fr_rm_q;

  logic [19:0]       sw_acc, swg_acc;
  logic [31:0]       prod;
  q15_t              sw_d, swg_d, sw_q, swg_q;
  logic              a_vld_q, a_force_q;

  q15_t              den;
  logic [30:0]       ratio_d, ratio_q;
  logic              d_vld_q, d_force_q;

  logic [37:0]       pct;
  logic [7:0]        g_d, g_q;
  logic              valid_q;

  assign start_edge = bus_io.start & ~start_q;
  assign init_edge  = bus_io.init & ~init_q;
  // An init edge in the same cycle as a start edge un-primes first.
  assign force_zero = bus_io.dt_mode & ~(primed_q & ~init_edge);
  assign t_diff     = {bus_io.t_in[7], bus_io.t_in} - {t_prev_q[7], t_prev_q};

  always_comb begin
    est_dt = t_diff[7:0];
    if (t_diff > 9'sd127)        est_dt = 8'sd127;
    else if (t_diff < -9'sd128)  est_dt = -8'sd128;
  end

  for (genvar i = 0; i < 3; i++) begin : g_mf
    trap_mf u_mf_t (.x_i(e_t_q),  .mf_i(e_tmf_q[i]),  .mu_o(mu_t[i]));
    trap_mf u_mf_d (.x_i(e_dt_q), .mf_i(e_dtmf_q[i]), .mu_o(mu_d[i]));
  end

  always_comb begin
    w_d = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_d[i*3+j] = (mu_t[i] < mu_d[j]) ? mu_t[i] : mu_d[j];
      end
    end
  end

  // Corner rules always contribute; edge and centre rules only in full mode.
  always_comb begin
    sw_acc  = '0;
    swg_acc = '0;
    prod    = '0;
    for (int k = 0; k < 9; k++) begin
      if (fr_rm_q || k == 0 || k == 2 || k == 6 || k == 8) begin
        prod    = 32'(w_q[k]) * gq_of(G_SGL[k]) + 32'd16384;
        sw_acc  = sw_acc + 20'(w_q[k]);
        swg_acc = swg_acc + 20'(prod >> 15);
      end
    end
    sw_d  = (sw_acc  > 20'd32767) ? Q15_ONE : sw_acc[15:0];
    swg_d = (swg_acc > 20'd32767) ? Q15_ONE : swg_acc[15:0];
  end

  always_comb begin
    den     = (sw_q == '0) ? EPS : sw_q;
    ratio_d = {swg_q, 15'b0} / {15'b0, den};
    pct     = (38'(ratio_q) * 38'd100) >> 15;
    g_d     = '0;
    if (!d_force_q) g_d = (pct > 38'd100) ? 8'd100 : pct[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q    <= 1'b0;
      init_q     <= 1'b0;
      primed_q   <= 1'b0;
      t_prev_q   <= '0;
      e_vld_q    <= 1'b0;
      e_force_q  <= 1'b0;
      e_rm_q     <= 1'b0;
      e_t_q      <= '0;
      e_dt_q     <= '0;
      e_tmf_q    <= '0;
      e_dtmf_q   <= '0;
      fr_vld_q   <= 1'b0;
      fr_force_q <= 1'b0;
      fr_rm_q    <= 1'b0;
      w_q        <= '0;
      a_vld_q    <= 1'b0;
      a_force_q  <= 1'b0;
      sw_q       <= '0;
      swg_q      <= '0;
      d_vld_q    <= 1'b0;
      d_force_q  <= 1'b0;
      ratio_q    <= '0;
      valid_q    <= 1'b0;
      g_q        <= '0;
    end else begin
      start_q <= bus_io.start;
      init_q  <= bus_io.init;
      if (start_edge) begin
        t_prev_q <= bus_io.t_in;
        primed_q <= 1'b1;
      end else if (init_edge) begin
        primed_q <= 1'b0;
      end
      e_vld_q <= start_edge;
      if (start_edge) begin
        e_force_q <= force_zero;
        e_rm_q    <= bus_io.reg_mode;
        e_t_q     <= bus_io.t_in;
        e_dt_q    <= bus_io.dt_mode ? est_dt : bus_io.dt_in;
        e_tmf_q   <= bus_io.t_mf;
        e_dtmf_q  <= bus_io.dt_mf;
      end
      fr_vld_q   <= e_vld_q;
      fr_force_q <= e_force_q;
      fr_rm_q    <= e_rm_q;
      w_q        <= w_d;
      a_vld_q    <= fr_vld_q;
      a_force_q  <= fr_force_q;
      sw_q       <= sw_d;
      swg_q      <= swg_d;
      d_vld_q    <= a_vld_q;
      d_force_q  <= a_force_q;
      ratio_q    <= ratio_d;
      valid_q    <= d_vld_q;
      if (d_vld_q) g_q <= g_d;
    end
  end

  assign bus_io.valid = valid_q;
  assign bus_io.g_out = g_q;

endmodule

// File: tb/tb_top_coprocessor.sv
// Self-checking bench for top_coprocessor against a behavioural fuzzy model.
module tb_top_coprocessor;

  logic clk;
  logic rst;
  top_coprocessor_if bif ();

  top_coprocessor dut (.clk(clk), .rst(rst), .bus_io(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int TMF [3][4] = '{'{-128, -64, -32, 0}, '{-16, 0, 0, 16}, '{0, 32, 64, 127}};
  int DMF [3][4] = '{'{-100, -50, -30, -5}, '{-10, 0, 0, 10}, '{5, 25, 35, 60}};
  int GS  [3][3] = '{'{100, 50, 30}, '{50, 50, 50}, '{80, 50, 0}};
  int TG  [10]   = '{-128, -64, -32, -16, 0, 16, 32, 64, 96, 127};
  int DG  [7]    = '{-60, -30, -10, 0, 10, 30, 60};

  int     n_tests, n_fail;
  longint cyc;
  bit     chk_en;
  int     last_g;
  int     exp_q [$];
  longint cyc_q [$];
  int     t_prev_m;
  bit     primed_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mu_m(int x, int a, int b, int c, int d);
    int r;
    if (x <= a || x >= d) return 0;
    if (b <= x && x <= c) return 32767;
    if (x < b) r = ((x - a) * 32768) / ((b - a) == 0 ? 1 : (b - a));
    else       r = ((d - x) * 32768) / ((d - c) == 0 ? 1 : (d - c));
    return (r > 32767) ? 32767 : r;
  endfunction

  function automatic int model_g(int t, int dt, bit rm);
    longint mt [3], md [3];
    longint sw, swg, w, gq, ratio, pct;
    for (int i = 0; i < 3; i++) begin
      mt[i] = mu_m(t, TMF[i][0], TMF[i][1], TMF[i][2], TMF[i][3]);
      md[i] = mu_m(dt, DMF[i][0], DMF[i][1], DMF[i][2], DMF[i][3]);
    end
    sw = 0;
    swg = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (rm || (i != 1 && j != 1)) begin
          w   = (mt[i] < md[j]) ? mt[i] : md[j];
          gq  = (GS[i][j] * 32767 + 50) / 100;
          sw  += w;
          swg += (w * gq + 16384) / 32768;
        end
      end
    end
    if (sw > 32767) sw = 32767;
    if (swg > 32767) swg = 32767;
    ratio = (swg * 32768) / ((sw < 1) ? 1 : sw);
    pct   = (ratio * 100) / 32768;
    return (pct > 100) ? 100 : int'(pct);
  endfunction

  // Launch one start edge; lit >= 0 pins the model to a hand-computed value.
  task automatic do_start(input int t, input int dt, input bit rm, input bit dm,
                          input bit with_init, input int lit);
    int est, g;
    @(negedge clk);
    bif.t_in     = 8'(t);
    bif.dt_in    = 8'(dt);
    bif.reg_mode = rm;
    bif.dt_mode  = dm;
    bif.start    = 1'b1;
    bif.init     = with_init;
    if (with_init) primed_m = 1'b0;
    est = t - t_prev_m;
    if (est > 127) est = 127;
    if (est < -128) est = -128;
    g = model_g(t, dm ? est : dt, rm);
    if (dm && !primed_m) g = 0;
    t_prev_m = t;
    primed_m = 1'b1;
    if (lit >= 0) chk($sformatf("model_g(T=%0d,dT=%0d,rm=%0d)", t, dt, rm), g, lit);
    exp_q.push_back(g);
    cyc_q.push_back(cyc + 5);
    @(negedge clk);
    bif.start = 1'b0;
    bif.init  = 1'b0;
  endtask

  task automatic do_init();
    @(negedge clk);
    bif.init = 1'b1;
    primed_m = 1'b0;
    @(negedge clk);
    bif.init = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    cyc_q.delete();
    last_g   = 0;
    primed_m = 1'b0;
    t_prev_m = 0;
    chk("reset_valid", bif.valid, 0);
    chk("reset_g_out", bif.g_out, 0);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (bif.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          chk("g_out", bif.g_out, exp_q[0]);
          chk("valid_cycle", cyc, cyc_q[0]);
          chk("g_le_100", bif.g_out <= 8'd100, 1);
          last_g = exp_q[0];
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
        end
      end else begin
        chk("g_out_hold", bif.g_out, last_g);
        if (exp_q.size() > 0 && cyc > cyc_q[0]) begin
          chk("missed_valid", 0, 1);
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
        end
      end
    end
  end

  initial begin
    int t;
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    chk_en   = 1'b0;
    last_g   = 0;
    t_prev_m = 0;
    primed_m = 1'b0;
    rst      = 1'b1;
    bif.start = 1'b0; bif.init = 1'b0; bif.reg_mode = 1'b0; bif.dt_mode = 1'b0;
    bif.t_in = '0; bif.dt_in = '0;
    for (int i = 0; i < 3; i++) begin
      bif.t_mf[i]  = {8'(TMF[i][0]), 8'(TMF[i][1]), 8'(TMF[i][2]), 8'(TMF[i][3])};
      bif.dt_mf[i] = {8'(DMF[i][0]), 8'(DMF[i][1]), 8'(DMF[i][2]), 8'(DMF[i][3])};
    end
    do_reset();

    chk("model_mu_dneg(-60)", mu_m(-60, DMF[0][0], DMF[0][1], DMF[0][2], DMF[0][3]), 26214);
    chk("model_mu_tneg(-64)", mu_m(-64, TMF[0][0], TMF[0][1], TMF[0][2], TMF[0][3]), 32767);

    do_start(0, 0, 1'b1, 1'b0, 1'b0, 50);
    do_start(0, 0, 1'b0, 1'b0, 1'b0, 0);
    do_start(-64, -60, 1'b1, 1'b0, 1'b0, 99);
    do_start(-64, -60, 1'b0, 1'b0, 1'b0, 99);
    do_start(-128, 127, 1'b1, 1'b0, 1'b0, 0);
    do_start(127, -128, 1'b1, 1'b0, 1'b0, -1);

    foreach (TG[i]) foreach (DG[j]) for (int m = 0; m < 2; m++)
      do_start(TG[i], DG[j], m[0], 1'b0, 1'b0, -1);

    for (int k = 0; k < 300; k++)
      do_start(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);

    do_init();
    do_start(5, 0, 1'b1, 1'b1, 1'b0, 0);
    for (int v = 0; v <= 38; v += 2) do_start(v, 0, 1'b1, 1'b1, 1'b0, -1);
    for (int v = 38; v >= 0; v -= 2) do_start(v, 0, 1'b0, 1'b1, 1'b0, -1);
    t = 0;
    for (int k = 0; k < 100; k++) begin
      t += int'($urandom_range(0, 10)) - 5;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      do_start(t, 0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, -1);
    end
    do_start(-10, 0, 1'b1, 1'b1, 1'b1, 0);
    do_start(-12, 0, 1'b1, 1'b1, 1'b0, -1);

    do_start(-64, -60, 1'b1, 1'b0, 1'b0, 99);
    do_reset();
    repeat (10) @(negedge clk);
    do_start(0, 0, 1'b1, 1'b0, 1'b0, 50);

    repeat (10) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
